mutex_arbiter_n: RTL and testbench



---
 rtl/arb_pkg.sv | 26 ++
 rtl/mutex_arbiter_n_if.sv | 30 +++
 rtl/rr_pick.sv | 25 ++
 rtl/mutex_arbiter_n.sv | 109 ++++++++++
 tb/tb_mutex_arbiter_n.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mutex arbiter (mutex_arbiter_n).
// Optional hold timeout is enabled with the ARB_HOLD_TIMEOUT_EN macro.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 32;

  // Index of the set bit in a one-hot vector; a zero vector yields 0.
  function automatic int unsigned onehot_to_index(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] next_ptr(input logic [31:0] idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mutex_arbiter_n_if.sv
// Request/grant bundle between requesters (master) and the mutex arbiter (slave).
// The timeout signal stays at 0 unless ARB_HOLD_TIMEOUT_EN is defined in the arbiter build.
interface mutex_arbiter_n_if #(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               timeout;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
// Rotates the request vector so ptr lands on bit 0, isolates the lowest set bit, then rotates back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_pick;

  always_comb begin
    rot      = NUM_REQ'({req, req} >> ptr);
    rot_pick = rot & (~rot + NUM_REQ'(1));
    pick     = NUM_REQ'(({rot_pick, rot_pick} << ptr) >> NUM_REQ);
    found    = |req;
  end

endmodule

// File: rtl/mutex_arbiter_n.sv
// Break-before-make round-robin mutex arbiter for NUM_REQ level requests.
// Define ARB_HOLD_TIMEOUT_EN to force a release after HOLD_MAX consecutive grant cycles.
module mutex_arbiter_n
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int HOLD_MAX = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  mutex_arbiter_n_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || HOLD_MAX < 1) begin : g_bad_cfg
    $error("mutex_arbiter_n: NUM_REQ must be 2..32 and HOLD_MAX at least 1");
  end

  arb_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant_q;
  logic               grant_valid_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] pick;
  logic               found;
  logic [ID_W-1:0]    pick_idx;
  logic               owner_req;
  logic               release_now;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .pick  (pick),
    .found (found)
  );

  assign pick_idx  = ID_W'(onehot_to_index(32'(pick)));
  assign owner_req = bus.req[grant_id_q];

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;

  // hold_cnt sits at 0 throughout IDLE, so every new grant starts counting from zero.
  assign hold_expired = (hold_cnt == HOLD_W'(HOLD_MAX - 1));
  assign release_now  = !owner_req || hold_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == ARB_BUSY) && owner_req && hold_expired;
      if (state == ARB_IDLE) begin
        hold_cnt <= '0;
      end else if (!release_now) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  assign release_now = !owner_req;
  assign timeout_q   = 1'b0;
`endif

  // Every release passes through IDLE for one cycle, even with other requests pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      ptr           <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state         <= ARB_BUSY;
            grant_q       <= pick;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_idx;
            ptr           <= ID_W'(next_ptr(32'(pick_idx), NUM_REQ));
          end
        end
        ARB_BUSY: begin
          if (release_now) begin
            state         <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
          end
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mutex_arbiter_n.sv
// Directed bench for mutex_arbiter_n with five requesters and HOLD_MAX = 8.
// Expectations for the hold test follow ARB_HOLD_TIMEOUT_EN when it is defined.
module tb_mutex_arbiter_n;

  localparam int NUM_REQ  = 5;
  localparam int ID_W     = 3;
  localparam int HOLD_MAX = 8;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mutex_arbiter_n_if #(.NUM_REQ(NUM_REQ)) bus ();

  mutex_arbiter_n #(
    .NUM_REQ  (NUM_REQ),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input int cycles);
    bus.req = r;
    repeat (cycles) step();
  endtask

  task automatic checkOutput(input string tag, input logic [NUM_REQ-1:0] g,
                             input logic [ID_W-1:0] id, input logic to);
    tests++;
    assert (bus.grant === g) else begin
      fails++;
      $error("FAIL %s grant observed %b expected %b", tag, bus.grant, g);
    end
    tests++;
    assert (bus.grant_valid === (|g)) else begin
      fails++;
      $error("FAIL %s grant_valid observed %b expected %b", tag, bus.grant_valid, |g);
    end
    tests++;
    assert (bus.grant_id === id) else begin
      fails++;
      $error("FAIL %s grant_id observed %0d expected %0d", tag, bus.grant_id, id);
    end
    tests++;
    assert (bus.timeout === to) else begin
      fails++;
      $error("FAIL %s timeout observed %b expected %b", tag, bus.timeout, to);
    end
  endtask

  initial begin
    bus.req = 5'b11111;
    rst     = 1'b1;
    repeat (2) step();
    checkOutput("reset", 5'b00000, 3'd0, 1'b0);

    rst = 1'b0;
    step();
    checkOutput("first_grant", 5'b00001, 3'd0, 1'b0);
    applyStimulus(5'b11111, 2);
    checkOutput("hold0", 5'b00001, 3'd0, 1'b0);

    // Sequential handover 0 -> 1 -> 2, each through one idle cycle
    applyStimulus(5'b11110, 1);
    checkOutput("gap0", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("grant1", 5'b00010, 3'd1, 1'b0);
    applyStimulus(5'b11100, 1);
    checkOutput("gap1", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("grant2", 5'b00100, 3'd2, 1'b0);

    // Owner 2 pulses low: 3, 0, 1 must be served before 2 again
    applyStimulus(5'b01111, 1);
    checkOutput("hold2", 5'b00100, 3'd2, 1'b0);
    applyStimulus(5'b01011, 1);
    checkOutput("gap2", 5'b00000, 3'd0, 1'b0);
    applyStimulus(5'b01111, 1);
    checkOutput("grant3", 5'b01000, 3'd3, 1'b0);
    applyStimulus(5'b00111, 1);
    checkOutput("gap3", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("rot_grant0", 5'b00001, 3'd0, 1'b0);
    applyStimulus(5'b00110, 1);
    checkOutput("gap_rot0", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("rot_grant1", 5'b00010, 3'd1, 1'b0);
    applyStimulus(5'b00100, 1);
    checkOutput("gap_rot1", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("rot_grant2", 5'b00100, 3'd2, 1'b0);

    // Owner 4 releases, pointer wraps to 0
    applyStimulus(5'b10000, 1);
    checkOutput("gap_to4", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("grant4", 5'b10000, 3'd4, 1'b0);
    applyStimulus(5'b10011, 1);
    checkOutput("hold4", 5'b10000, 3'd4, 1'b0);
    applyStimulus(5'b00011, 1);
    checkOutput("gap4", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("wrap_grant0", 5'b00001, 3'd0, 1'b0);

    // Single requester re-granted back-to-back with one idle cycle between
    applyStimulus(5'b00000, 1);
    checkOutput("gap_single", 5'b00000, 3'd0, 1'b0);
    applyStimulus(5'b00001, 1);
    checkOutput("regrant0", 5'b00001, 3'd0, 1'b0);

    // Request appearing during the gap is taken at the next edge
    applyStimulus(5'b00000, 1);
    checkOutput("gap_change", 5'b00000, 3'd0, 1'b0);
    applyStimulus(5'b01000, 1);
    checkOutput("gap_change_grant", 5'b01000, 3'd3, 1'b0);
    applyStimulus(5'b00000, 1);
    checkOutput("gap_pre_hold", 5'b00000, 3'd0, 1'b0);

    // Long hold by a lone requester: bounded only with the timeout build
    bus.req = 5'b00001;
    for (int c = 0; c < 30; c++) begin
      logic expired;
      step();
      expired = TO_EN && ((c % (HOLD_MAX + 1)) == HOLD_MAX);
      checkOutput("hold_timeout", expired ? 5'b00000 : 5'b00001, 3'd0, expired);
    end

    applyStimulus(5'b00100, 1);
    checkOutput("gap_pre_rst", 5'b00000, 3'd0, 1'b0);
    step();
    checkOutput("grant2_pre_rst", 5'b00100, 3'd2, 1'b0);

    // Asynchronous reset mid-grant, away from any clock edge
    #3 rst = 1'b1;
    #1 checkOutput("async_rst", 5'b00000, 3'd0, 1'b0);
    #1 rst = 1'b0;
    step();
    checkOutput("post_rst_grant", 5'b00100, 3'd2, 1'b0);

    // Pointer was 3 before this reset; a restart at 0 picks requester 1, not 4
    bus.req = 5'b10010;
    #3 rst = 1'b1;
    #1 checkOutput("async_rst2", 5'b00000, 3'd0, 1'b0);
    #1 rst = 1'b0;
    step();
    checkOutput("ptr_restart", 5'b00010, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
